// File: rtl/nibble_packer_pkg.sv
// Shared read-side definitions: packer FSM encoding and slot-counter width helper.
package nibble_packer_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Slot-counter width; a single slot would still need one bit to hold zero.
    function automatic int unsigned cnt_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/nibble_packer.sv
// Pops RATIO WIDTH-bit words from the async FIFO read side and presents them packed over valid/ready.
// Optional even-parity output par_o is enabled by defining PACKER_PARITY_EN.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RATIO = 4
) (
    input  logic                   rclk,
    input  logic                   rst_i,
    input  logic                   fifo_empty_i,
    input  logic [WIDTH-1:0]       fifo_dat_i,
    output logic                   fifo_ren_o,
    output logic [WIDTH*RATIO-1:0] dat_o,
    output logic                   vld_o,
    input  logic                   rdy_i
`ifdef PACKER_PARITY_EN
    ,
    output logic                   par_o
`endif
);

    localparam int unsigned CW = cnt_w(RATIO);
    localparam int unsigned OW = WIDTH * RATIO;
    localparam logic [CW:0]   SLOTS = (CW + 1)'(RATIO);
    localparam logic [CW-1:0] LAST  = CW'(RATIO - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            pend_q;
    logic [OW-1:0]   buf_q;
    logic [CW:0]     inflight;
    logic [OW-1:0]   word_next;

    always_comb begin
        // Slots already filled plus the read still in flight must never exceed RATIO.
        inflight   = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
        fifo_ren_o = !rst_i && (state_q == ST_FILL) && !fifo_empty_i && (inflight < SLOTS);
        word_next  = {fifo_dat_i, buf_q[OW-WIDTH-1:0]};
    end

    always_ff @(posedge rclk) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
            dat_o   <= '0;
            vld_o   <= 1'b0;
`ifdef PACKER_PARITY_EN
            par_o   <= 1'b0;
`endif
        end else begin
            pend_q <= fifo_ren_o;
            unique case (state_q)
                ST_FILL: begin
                    if (pend_q) begin
                        buf_q[cnt_q*WIDTH +: WIDTH] <= fifo_dat_i;
                        if (cnt_q == LAST) begin
                            dat_o   <= word_next;
                            vld_o   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_DRAIN;
`ifdef PACKER_PARITY_EN
                            par_o   <= ^word_next;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rdy_i) begin
                        vld_o   <= 1'b0;
                        state_q <= ST_FILL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer with a behavioural 1-cycle-latency FIFO on the read side.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [3:0]  fifo_dat = '0;
    logic        ren;
    logic [15:0] dat;
    logic        vld;
    logic        rdy = 1'b1;
`ifdef PACKER_PARITY_EN
    logic        par;
`endif

    int tests = 0;
    int fails = 0;

    // FIFO model state
    logic [3:0] fq[$];
    int pushed_n = 0;
    int popped_n = 0;
    int underflow = 0;

    // monitor state
    int ren_cnt, ren_in_drain, ren_when_empty, held_bad, burst;
    int bursts[$];
    logic [15:0] out_q[$];
    logic prev_vld, prev_rdy;
    logic [15:0] prev_dat;

    nibble_packer #(.WIDTH(4), .RATIO(4)) dut (
        .rclk         (clk),
        .rst_i        (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_dat_i   (fifo_dat),
        .fifo_ren_o   (ren),
        .dat_o        (dat),
        .vld_o        (vld),
        .rdy_i        (rdy)
`ifdef PACKER_PARITY_EN
        ,
        .par_o        (par)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = (pushed_n == popped_n);

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            popped_n <= pushed_n;
            fifo_dat <= '0;
        end else if (ren) begin
            if (fq.size() == 0) begin
                underflow++;
            end else begin
                fifo_dat <= fq.pop_front();
                popped_n <= popped_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
            prev_dat = '0;
            burst    = 0;
        end else begin
            if (ren) begin
                ren_cnt++;
                burst++;
            end
            if (ren && vld) ren_in_drain++;
            if (ren && fifo_empty) ren_when_empty++;
            if (prev_vld && !prev_rdy && (!vld || dat !== prev_dat)) held_bad++;
            if (vld && rdy) begin
                out_q.push_back(dat);
                bursts.push_back(burst);
                burst = 0;
            end
            prev_vld = vld;
            prev_rdy = rdy;
            prev_dat = dat;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] v);
        fq.push_back(v);
        pushed_n++;
    endtask

    task automatic clear_mon();
        ren_cnt = 0;
        ren_in_drain = 0;
        ren_when_empty = 0;
        held_bad = 0;
        burst = 0;
        underflow = 0;
        out_q.delete();
        bursts.delete();
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests++;
        if (ren !== 1'b0) begin fails++; $display("FAIL reset_ren got %b want 0", ren); end
        tests++;
        if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", vld); end
        tests++;
        if (dat !== 16'h0000) begin fails++; $display("FAIL reset_dat got %h want 0000", dat); end
`ifdef PACKER_PARITY_EN
        tests++;
        if (par !== 1'b0) begin fails++; $display("FAIL reset_par got %b want 0", par); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] renv;
        logic [7:0] vldv;
        clear_mon();
        rdy = 1'b1;
        step();
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            renv[i] = ren;
            vldv[i] = vld;
        end
        step();
        tests++;
        if (renv !== 8'h0F) begin fails++; $display("FAIL basic_ren_timing got %b want 00001111", renv); end
        tests++;
        if (vldv !== 8'h20) begin fails++; $display("FAIL basic_vld_timing got %b want 00100000", vldv); end
        tests++;
        if (out_q.size() !== 1 || out_q[0] !== 16'h4321) begin
            fails++;
            $display("FAIL basic_word got n=%0d w=%h want n=1 w=4321", out_q.size(),
                     (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
        end
        tests++;
        if (ren_cnt !== 4 || underflow !== 0) begin
            fails++;
            $display("FAIL basic_ren_count got %0d underflow %0d want 4 and 0", ren_cnt, underflow);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        step();
        rdy = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_vld(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_vld_timeout got no vld want vld"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (vld !== 1'b1 || dat !== 16'h4321 || ren !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got vld=%b dat=%h ren=%b want 1 4321 0",
                         i, vld, dat, ren);
            end
        end
        step();
        rdy = 1'b1;
        wait_words(1, ok);
        step();
        step();
        tests++;
        if (!ok || out_q.size() !== 1 || out_q[0] !== 16'h4321) begin
            fails++;
            $display("FAIL bp_handshake got n=%0d want one word 4321", out_q.size());
        end
        tests++;
        if (vld !== 1'b0 || held_bad !== 0) begin
            fails++;
            $display("FAIL bp_release got vld=%b held_bad=%0d want 0 0", vld, held_bad);
        end
    endtask

    task automatic test_empty_gap();
        bit ok;
        clear_mon();
        rdy = 1'b1;
        step();
        push(4'h5); push(4'h6);
        repeat (7) step();
        tests++;
        if (vld !== 1'b0 || ren_cnt !== 2) begin
            fails++;
            $display("FAIL gap_partial got vld=%b ren_cnt=%0d want 0 2", vld, ren_cnt);
        end
        push(4'h7); push(4'h8);
        wait_words(1, ok);
        tests++;
        if (!ok || out_q[0] !== 16'h8765) begin
            fails++;
            $display("FAIL gap_word got ok=%b w=%h want 8765", ok,
                     (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
        end
        tests++;
        if (ren_cnt !== 4 || ren_when_empty !== 0 || underflow !== 0) begin
            fails++;
            $display("FAIL gap_ren got cnt=%0d empty_ren=%0d uf=%0d want 4 0 0",
                     ren_cnt, ren_when_empty, underflow);
        end
    endtask

    task automatic test_reset_midword();
        bit ok;
        clear_mon();
        rdy = 1'b1;
        step();
        push(4'hA); push(4'hB); push(4'hC);
        repeat (6) step();
        tests++;
        if (vld !== 1'b0 || ren_cnt !== 3) begin
            fails++;
            $display("FAIL rst_mid_partial got vld=%b ren_cnt=%0d want 0 3", vld, ren_cnt);
        end
        rst = 1'b1;
        step();
        tests++;
        if (vld !== 1'b0 || ren !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_during got vld=%b ren=%b want 0 0", vld, ren);
        end
        rst = 1'b0;
        step();
        clear_mon();
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_words(1, ok);
        tests++;
        if (!ok || out_q[0] !== 16'h4321) begin
            fails++;
            $display("FAIL rst_mid_word got ok=%b w=%h want 4321", ok,
                     (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] e;
        logic [3:0] nib;
        step();
        clear_mon();
        rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                nib = 4'((k * 4 + j + 3) % 16);
                push(nib);
            end
        end
        wait_words(8, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d words want 8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            for (int j = 0; j < 4; j++) begin
                e[j*4 +: 4] = 4'((k * 4 + j + 3) % 16);
            end
            tests++;
            if (out_q[k] !== e || bursts[k] !== 4) begin
                fails++;
                $display("FAIL b2b_word %0d got %h burst %0d want %h burst 4",
                         k, out_q[k], bursts[k], e);
            end
        end
        tests++;
        if (ren_cnt !== 32 || ren_in_drain !== 0 || underflow !== 0) begin
            fails++;
            $display("FAIL b2b_ren got cnt=%0d drain_ren=%0d uf=%0d want 32 0 0",
                     ren_cnt, ren_in_drain, underflow);
        end
    endtask

`ifdef PACKER_PARITY_EN
    task automatic test_parity();
        bit ok;
        step();
        clear_mon();
        rdy = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_vld(ok);
        tests++;
        if (!ok || dat !== 16'h4321 || par !== 1'b1) begin
            fails++;
            $display("FAIL parity_4321 got dat=%h par=%b want 4321 1", dat, par);
        end
        step();
        rdy = 1'b1;
        step();
        step();
        rdy = 1'b0;
        push(4'h0); push(4'h0); push(4'h3); push(4'h3);
        wait_vld(ok);
        tests++;
        if (!ok || dat !== 16'h3300 || par !== 1'b0) begin
            fails++;
            $display("FAIL parity_3300 got dat=%h par=%b want 3300 0", dat, par);
        end
        step();
        rdy = 1'b1;
        step();
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_gap();
        test_reset_midword();
        test_back_to_back();
`ifdef PACKER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
